trees_spawn_scheduler: RTL and testbench

- Sequences the tree layer by driving the per-tree enable vector consumed by the trees top.
- Spawns trees into free slots at a speed-dependent interval, using a pseudo-random starting slot.
- Retires slots when a tree reports it has left the screen.
- Freezes spawning on end of level and signals when the field has drained.

---
 rtl/trees_pkg.sv | 30 +++
 rtl/trees_lfsr16.sv | 27 ++
 rtl/trees_spawn_scheduler.sv | 146 ++++++++++++++
 tb/tb_trees_spawn_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trees_pkg.sv
// Shared types and constants for the tree-layer spawn logic.
// Holds the scheduler state encoding, LFSR taps and the spawn interval rule.
package trees_pkg;

  localparam int TREES_COUNT_DEF   = 16;
  localparam int BASE_INTERVAL_DEF = 20;
  localparam int MIN_INTERVAL_DEF  = 3;

  // Galois right-shift form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    SP_IDLE,
    SP_WAIT,
    SP_SEARCH,
    SP_DRAIN
  } spawn_state_t;

  // Faster levels shorten the interval; only the low speed byte counts, negatives act as 0
  function automatic int spawn_interval(input logic signed [31:0] speed,
                                        input int base_iv,
                                        input int min_iv);
    int s;
    int cut;
    s   = speed[31] ? 0 : int'({24'd0, speed[7:0]});
    cut = (s > (base_iv - min_iv)) ? (base_iv - min_iv) : s;
    return base_iv - cut;
  endfunction

endpackage

// File: rtl/trees_lfsr16.sv
// Free-running 16-bit Galois LFSR with a parameterised seed and low-bit output tap.
// Shared by the random spawners of the game.
module trees_lfsr16
  import trees_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             i_en,
  output logic [OUT_W-1:0] o_rand
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_lfsr <= SEED;
    end else if (i_en) begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign o_rand = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/trees_spawn_scheduler.sv
// Drives the per-slot tree enables: timed spawns into a random free slot,
// retires on treeDone, and drains the field when the level ends.
module trees_spawn_scheduler
  import trees_pkg::*;
#(
  parameter int          TREES_COUNT   = TREES_COUNT_DEF,
  parameter int          BASE_INTERVAL = BASE_INTERVAL_DEF,
  parameter int          MIN_INTERVAL  = MIN_INTERVAL_DEF,
  parameter int          MAX_ACTIVE    = 10,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                               clk,
  input  logic                               resetN,
  input  logic                               startOfLevel,
  input  logic                               endLevel,
  input  logic                               oneTensSec,
  input  logic signed [31:0]                 levelSpeed,
  input  logic [TREES_COUNT-1:0]             treeDone,
  output logic [TREES_COUNT-1:0]             enableTreesVector,
  output logic [$clog2(TREES_COUNT+1)-1:0]   activeCount,
  output logic                               levelDrained
);

  localparam int PW = $clog2(TREES_COUNT);
  localparam int AW = $clog2(TREES_COUNT + 1);
  localparam int CW = $clog2(BASE_INTERVAL + 1);

  spawn_state_t           r_state, w_state_next;
  logic [CW-1:0]          r_cnt, w_cnt_next;
  logic [PW-1:0]          r_ptr, w_ptr_next;
  logic [PW-1:0]          r_scanned, w_scanned_next;
  logic [TREES_COUNT-1:0] r_enable, w_enable_next, w_set_mask;
  logic [AW-1:0]          r_active, w_active_next;
  logic                   r_drained, w_drained_next;
  logic                   w_clear_all;
  logic [PW-1:0]          w_rand;
  logic [CW-1:0]          w_interval;

  trees_lfsr16 #(
    .SEED  (LFSR_SEED),
    .OUT_W (PW)
  ) u_lfsr (
    .clk    (clk),
    .resetN (resetN),
    .i_en   (1'b1),
    .o_rand (w_rand)
  );

  assign w_interval = CW'(spawn_interval(levelSpeed, BASE_INTERVAL, MIN_INTERVAL));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state   <= SP_IDLE;
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_scanned <= '0;
      r_enable  <= '0;
      r_active  <= '0;
      r_drained <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_ptr     <= w_ptr_next;
      r_scanned <= w_scanned_next;
      r_enable  <= w_enable_next;
      r_active  <= w_active_next;
      r_drained <= w_drained_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_ptr_next     = r_ptr;
    w_scanned_next = r_scanned;
    w_set_mask     = '0;
    w_clear_all    = 1'b0;
    w_drained_next = 1'b0;

    unique case (r_state)
      SP_IDLE: ;
      SP_WAIT: begin
        if (endLevel) begin
          w_state_next = SP_DRAIN;
        end else if (r_cnt == '0) begin
          w_state_next   = SP_SEARCH;
          w_ptr_next     = w_rand;
          w_scanned_next = '0;
        end else if (oneTensSec) begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      SP_SEARCH: begin
        // A full field or a full lap both drop this spawn opportunity
        if (endLevel) begin
          w_state_next = SP_DRAIN;
        end else if (r_active >= AW'(MAX_ACTIVE)) begin
          w_state_next = SP_WAIT;
          w_cnt_next   = w_interval;
        end else if (!r_enable[r_ptr]) begin
          w_set_mask[r_ptr] = 1'b1;
          w_state_next      = SP_WAIT;
          w_cnt_next        = w_interval;
        end else if (r_scanned == PW'(TREES_COUNT - 1)) begin
          w_state_next = SP_WAIT;
          w_cnt_next   = w_interval;
        end else begin
          w_ptr_next     = r_ptr + PW'(1);
          w_scanned_next = r_scanned + PW'(1);
        end
      end
      SP_DRAIN: begin
        if (r_active == '0) begin
          w_drained_next = 1'b1;
          w_state_next   = SP_IDLE;
        end
      end
      default: w_state_next = SP_IDLE;
    endcase

    if (startOfLevel) begin
      w_clear_all    = 1'b1;
      w_set_mask     = '0;
      w_drained_next = 1'b0;
      w_state_next   = SP_WAIT;
      w_cnt_next     = w_interval;
    end
  end

  // Slot retire and spawn-set are independent per bit; SEARCH never picks an enabled slot
  for (genvar gi = 0; gi < TREES_COUNT; gi++) begin : g_slot
    assign w_enable_next[gi] = ~w_clear_all & ((r_enable[gi] & ~treeDone[gi]) | w_set_mask[gi]);
  end

  always_comb begin
    w_active_next = '0;
    for (int i = 0; i < TREES_COUNT; i++) begin
      w_active_next = w_active_next + AW'(w_enable_next[i]);
    end
  end

  assign enableTreesVector = r_enable;
  assign activeCount       = r_active;
  assign levelDrained      = r_drained;

endmodule

// File: tb/tb_trees_spawn_scheduler.sv
// Randomized scoreboard bench for trees_spawn_scheduler against a behavioural model.
module tb_trees_spawn_scheduler;

  localparam int          N    = 16;
  localparam int          BASE = 20;
  localparam int          MINI = 3;
  localparam int          MAXA = 10;
  localparam logic [15:0] SEED = 16'hACE1;

  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_SEARCH = 2, PH_DRAIN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      resetN;
  logic                      startOfLevel;
  logic                      endLevel;
  logic                      oneTensSec;
  logic signed [31:0]        levelSpeed;
  logic [N-1:0]              treeDone;
  logic [N-1:0]              enableTreesVector;
  logic [$clog2(N+1)-1:0]    activeCount;
  logic                      levelDrained;

  trees_spawn_scheduler #(
    .TREES_COUNT   (N),
    .BASE_INTERVAL (BASE),
    .MIN_INTERVAL  (MINI),
    .MAX_ACTIVE    (MAXA),
    .LFSR_SEED     (SEED)
  ) dut (
    .clk               (clk),
    .resetN            (resetN),
    .startOfLevel      (startOfLevel),
    .endLevel          (endLevel),
    .oneTensSec        (oneTensSec),
    .levelSpeed        (levelSpeed),
    .treeDone          (treeDone),
    .enableTreesVector (enableTreesVector),
    .activeCount       (activeCount),
    .levelDrained      (levelDrained)
  );

  typedef struct {
    int           cyc;
    logic [N-1:0] en;
    int           cnt;
    logic         drn;
  } exp_t;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   drain_seen = 0;

  function automatic int popc(input logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int exp_interval(input int spd);
    int s = (spd < 0) ? 0 : (spd % 256);
    return BASE - ((s > BASE - MINI) ? (BASE - MINI) : s);
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [N-1:0] pick_one(input logic [N-1:0] v);
    logic [N-1:0] r = '0;
    int start = int'($urandom_range(N - 1));
    for (int i = 0; i < N; i++) begin
      if (v[(start + i) % N]) begin
        r[(start + i) % N] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  // Reference model: tree slots as a bit set, a tick countdown and a lap-limited slot hunt
  logic [N-1:0] m_en;
  logic [N-1:0] m_nxt;
  logic [15:0]  m_lfsr;
  int           m_phase, m_ticks, m_ptr, m_tried, m_act, m_cyc;
  logic         m_drn;

  initial begin
    m_en = '0; m_phase = PH_IDLE; m_ticks = 0; m_ptr = 0; m_tried = 0;
    m_lfsr = SEED; m_cyc = 0;
    forever begin
      @(posedge clk);
      m_cyc++;
      m_drn = 1'b0;
      if (!resetN) begin
        m_nxt = '0; m_phase = PH_IDLE; m_ticks = 0; m_lfsr = SEED;
      end else begin
        m_act = popc(m_en);
        m_nxt = m_en & ~treeDone;
        if (startOfLevel) begin
          m_nxt   = '0;
          m_phase = PH_WAIT;
          m_ticks = exp_interval(levelSpeed);
        end else if (m_phase == PH_WAIT) begin
          if (endLevel) m_phase = PH_DRAIN;
          else if (m_ticks == 0) begin
            m_phase = PH_SEARCH;
            m_ptr   = int'(m_lfsr) % N;
            m_tried = 0;
          end else if (oneTensSec) m_ticks--;
        end else if (m_phase == PH_SEARCH) begin
          if (endLevel) m_phase = PH_DRAIN;
          else if (m_act >= MAXA || m_en[m_ptr] == 1'b0 || m_tried == N - 1) begin
            if (m_act < MAXA && m_en[m_ptr] == 1'b0) m_nxt[m_ptr] = 1'b1;
            m_phase = PH_WAIT;
            m_ticks = exp_interval(levelSpeed);
          end else begin
            m_ptr = (m_ptr + 1) % N;
            m_tried++;
          end
        end else if (m_phase == PH_DRAIN) begin
          if (m_act == 0) begin
            m_drn   = 1'b1;
            m_phase = PH_IDLE;
          end
        end
        m_lfsr = lfsr_step(m_lfsr);
      end
      if (m_nxt != m_en || m_drn) sb_q.push_back('{m_cyc, m_nxt, popc(m_nxt), m_drn});
      m_en = m_nxt;
    end
  end

  // Monitor: every visible output change (or drain pulse) consumes one expected event
  initial begin
    logic [N-1:0] last_en;
    int           last_cnt;
    int           mcyc;
    exp_t         e;
    last_en = '0; last_cnt = 0; mcyc = 0;
    forever begin
      @(negedge clk);
      mcyc++;
      if (levelDrained === 1'b1) drain_seen++;
      if (enableTreesVector !== last_en || int'(activeCount) != last_cnt || levelDrained !== 1'b0) begin
        compared++;
        if (sb_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_event cyc=%0d got en=%h cnt=%0d drn=%b, required no change",
                   mcyc, enableTreesVector, activeCount, levelDrained);
        end else begin
          e = sb_q.pop_front();
          if (e.cyc != mcyc || e.en !== enableTreesVector || e.cnt != int'(activeCount) ||
              e.drn !== levelDrained) begin
            mismatched++;
            $display("FAIL event got cyc=%0d en=%h cnt=%0d drn=%b, required cyc=%0d en=%h cnt=%0d drn=%b",
                     mcyc, enableTreesVector, activeCount, levelDrained, e.cyc, e.en, e.cnt, e.drn);
          end else begin
            $display("event ok cyc=%0d en=%h cnt=%0d drn=%b", mcyc, e.en, e.cnt, e.drn);
          end
        end
        last_en  = enableTreesVector;
        last_cnt = int'(activeCount);
      end
    end
  end

  task automatic check_int(input string nm, input int got, input int req);
    compared++;
    if (got != req) begin
      mismatched++;
      $display("FAIL %s got %0d required %0d", nm, got, req);
    end else begin
      $display("check ok %s = %0d", nm, got);
    end
  endtask

  task automatic run_random(input int ncyc, input int tick_period, input int done_pct,
                            input bit retire_on_search, input bit regular);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      startOfLevel = 1'b0;
      oneTensSec   = regular ? ((c % tick_period) == tick_period - 1)
                             : ($urandom_range(tick_period - 1) == 0);
      treeDone     = '0;
      if (int'($urandom_range(99)) < done_pct) treeDone = N'($urandom) & N'($urandom) & N'($urandom);
      if (retire_on_search && m_phase == PH_SEARCH && m_en != '0) treeDone = treeDone | pick_one(m_en);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    startOfLevel = 1'b1;
    oneTensSec   = 1'b0;
    treeDone     = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bit found;
    resetN = 1'b0; startOfLevel = 1'b0; endLevel = 1'b0; oneTensSec = 1'b0;
    levelSpeed = 0; treeDone = '0;
    repeat (3) @(negedge clk);
    check_int("reset_enables", int'(enableTreesVector), 0);
    check_int("reset_count", int'(activeCount), 0);
    check_int("reset_drained", int'(levelDrained), 0);
    resetN = 1'b1;

    // First spawn: 20 ticks (every 4 clks) plus the search, no second spawn yet
    levelSpeed = 0;
    pulse_start();
    run_random(110, 4, 0, 1'b0, 1'b1);
    check_int("first_spawn_count", int'(activeCount), 1);
    check_int("first_spawn_bits", popc(enableTreesVector), 1);

    levelSpeed = 50;
    run_random(300, 3, 20, 1'b0, 1'b0);
    levelSpeed = -5;
    run_random(300, 2, 20, 1'b1, 1'b0);
    levelSpeed = 10;
    run_random(200, 2, 30, 1'b1, 1'b0);

    // Saturation: no retires, short interval
    levelSpeed = 100;
    run_random(400, 2, 0, 1'b0, 1'b0);
    check_int("saturated_count", int'(activeCount), MAXA);
    check_int("saturated_bits", popc(enableTreesVector), MAXA);
    run_random(60, 2, 0, 1'b0, 1'b0);
    check_int("saturated_hold", int'(activeCount), MAXA);

    // Drain: retire one live slot every third clk with endLevel held
    d0 = drain_seen;
    endLevel = 1'b1;
    for (int k = 0; k < 300 && drain_seen == d0; k++) begin
      @(negedge clk);
      oneTensSec = ($urandom_range(1) == 0);
      treeDone   = ((k % 3) == 0) ? pick_one(m_en) : '0;
    end
    treeDone = '0;
    run_random(10, 2, 0, 1'b0, 1'b0);
    check_int("drain_pulses", drain_seen - d0, 1);
    check_int("drain_enables", int'(enableTreesVector), 0);
    endLevel = 1'b0;
    run_random(60, 2, 0, 1'b0, 1'b0);
    check_int("idle_no_spawn", int'(activeCount), 0);

    // startOfLevel wins over endLevel and clears live enables
    levelSpeed = 60;
    pulse_start();
    run_random(150, 2, 10, 1'b0, 1'b0);
    @(negedge clk);
    startOfLevel = 1'b1; endLevel = 1'b1; treeDone = '0; oneTensSec = 1'b0;
    @(negedge clk);
    startOfLevel = 1'b0; endLevel = 1'b0;
    check_int("start_over_end_enables", popc(enableTreesVector), 0);
    run_random(100, 2, 10, 1'b1, 1'b0);

    // Asynchronous reset while the model sits in SEARCH
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      run_random(1, 2, 0, 1'b0, 1'b0);
      if (m_phase == PH_SEARCH && m_en != '0) found = 1'b1;
    end
    check_int("search_reached", int'(found), 1);
    d0 = drain_seen;
    #2 resetN = 1'b0;
    #1;
    check_int("async_reset_enables", int'(enableTreesVector), 0);
    check_int("async_reset_count", int'(activeCount), 0);
    repeat (3) @(negedge clk);
    check_int("reset_no_drain", drain_seen - d0, 0);
    resetN = 1'b1;

    levelSpeed = -5;
    pulse_start();
    run_random(250, 2, 25, 1'b1, 1'b0);
    run_random(3, 2, 0, 1'b0, 1'b0);

    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      compared++;
      mismatched++;
      $display("FAIL missing_event got none, required cyc=%0d en=%h cnt=%0d drn=%b",
               e.cyc, e.en, e.cnt, e.drn);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
